// File: rtl/game_timer_sequencer_if.sv
// rtl/game_timer_sequencer_if.sv - controller-side signal bundle for the game countdown timer
interface game_timer_sequencer_if;
    logic       timer_reconfig;
    logic       timer_enable;
    logic [3:0] tens_out;
    logic [3:0] ones_out;
    logic       tick;
    logic       time_out;
    logic       warn;

    modport master (
        output timer_reconfig, timer_enable,
        input  tens_out, ones_out, tick, time_out, warn
    );

    modport slave (
        input  timer_reconfig, timer_enable,
        output tens_out, ones_out, tick, time_out, warn
    );
endinterface

// File: rtl/game_timer_sequencer.sv
// rtl/game_timer_sequencer.sv - two-digit BCD countdown with prescaler, sticky time_out
// Optional low-time indicator enabled by defining TIMER_WARN_EN.
module game_timer_sequencer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESET_TENS   = 9,
    parameter int PRESET_ONES   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    game_timer_sequencer_if.slave tif
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0] P_TENS = (PRESET_TENS > 9) ? 4'd9 : 4'(PRESET_TENS);
    localparam logic [3:0] P_ONES = (PRESET_ONES > 9) ? 4'd9 : 4'(PRESET_ONES);
    localparam logic PRESET_ZERO = (P_TENS == 4'd0) && (P_ONES == 4'd0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADED  = 2'd1,
        RUNNING = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          time_out_q, time_out_d;
    logic [3:0]    dec_tens, dec_ones;

    // BCD decrement; only used from RUNNING, where the count is never 00
    always_comb begin
        dec_tens = tens_q;
        dec_ones = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        time_out_d = time_out_q;
        if (tif.timer_reconfig) begin
            tens_d     = P_TENS;
            ones_d     = P_ONES;
            presc_d    = '0;
            time_out_d = PRESET_ZERO;
            state_d    = PRESET_ZERO ? EXPIRED : LOADED;
        end else begin
            case (state_q)
                IDLE: ;
                LOADED: begin
                    if (tif.timer_enable) state_d = RUNNING;
                end
                RUNNING: begin
                    // Pausing wins over a coincident terminal count; prescaler keeps its partial second
                    if (!tif.timer_enable) begin
                        state_d = LOADED;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        tens_d  = dec_tens;
                        ones_d  = dec_ones;
                        if (dec_tens == 4'd0 && dec_ones == 4'd0) begin
                            time_out_d = 1'b1;
                            state_d    = EXPIRED;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                EXPIRED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            time_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            time_out_q <= time_out_d;
        end
    end

`ifdef TIMER_WARN_EN
    logic warn_q, warn_d;

    always_comb begin
        warn_d = 1'b0;
        if (!tif.timer_reconfig && (state_d == RUNNING || state_d == LOADED))
            warn_d = (tens_d == 4'd0) || (tens_d == 4'd1 && ones_d == 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) warn_q <= 1'b0;
        else      warn_q <= warn_d;
    end

    assign tif.warn = warn_q;
`else
    assign tif.warn = 1'b0;
`endif

    assign tif.tens_out = tens_q;
    assign tif.ones_out = ones_q;
    assign tif.tick     = tick_q;
    assign tif.time_out = time_out_q;
endmodule

// File: tb/tb_game_timer_sequencer.sv
// tb/tb_game_timer_sequencer.sv - directed self-checking bench for game_timer_sequencer
module tb_game_timer_sequencer;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    game_timer_sequencer_if tif ();
    game_timer_sequencer_if tif0 ();

    game_timer_sequencer #(.TICKS_PER_SEC(4), .PRESET_TENS(9), .PRESET_ONES(9)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif.slave)
    );

    game_timer_sequencer #(.TICKS_PER_SEC(4), .PRESET_TENS(0), .PRESET_ONES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .tif (tif0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reconfig();
        tif.timer_reconfig = 1'b1;
        step();
        tif.timer_reconfig = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tif.timer_reconfig = 1'b0;  tif.timer_enable = 1'b0;
        tif0.timer_reconfig = 1'b0; tif0.timer_enable = 1'b0;
        repeat (3) step();
        vectors++;
        if ({tif.tens_out, tif.ones_out, tif.tick, tif.time_out, tif.warn} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got t=%0d o=%0d tick=%b to=%b warn=%b want all 0",
                     tif.tens_out, tif.ones_out, tif.tick, tif.time_out, tif.warn);
        end
        rst = 1'b1;
        tif.timer_enable = 1'b1;
        repeat (5) step();
        vectors++;
        if ({tif.tens_out, tif.ones_out, tif.tick, tif.time_out} !== 10'd0) begin
            miscompares++;
            $display("FAIL idle_ignores_enable got t=%0d o=%0d tick=%b to=%b want 0/0/0/0",
                     tif.tens_out, tif.ones_out, tif.tick, tif.time_out);
        end
        tif.timer_enable = 1'b0;
    endtask

    task automatic test_hold_loaded();
        int ticks;
        pulse_reconfig();
        vectors++;
        if (tif.tens_out !== 4'd9 || tif.ones_out !== 4'd9 || tif.time_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reconfig_load got %0d%0d to=%b want 99 to=0", tif.tens_out, tif.ones_out, tif.time_out);
        end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tif.tick === 1'b1) ticks++;
        end
        vectors++;
        if (tif.tens_out !== 4'd9 || tif.ones_out !== 4'd9 || ticks != 0 || tif.warn !== 1'b0) begin
            miscompares++;
            $display("FAIL loaded_hold got %0d%0d ticks=%0d warn=%b want 99 ticks=0 warn=0",
                     tif.tens_out, tif.ones_out, ticks, tif.warn);
        end
    endtask

    task automatic test_countdown();
        int  et, eo, nticks;
        logic exp_tick, exp_to, exp_warn;
        pulse_reconfig();
        et = 9; eo = 9; nticks = 0;
        tif.timer_enable = 1'b1;
        for (int cyc = 1; cyc <= 405; cyc++) begin
            step();
            exp_tick = (cyc >= 5) && (((cyc - 5) % 4) == 0) && (nticks < 99);
            if (exp_tick) begin
                nticks++;
                if (eo > 0) eo--;
                else begin eo = 9; et--; end
            end
            exp_to = (et == 0 && eo == 0);
`ifdef TIMER_WARN_EN
            exp_warn = !exp_to && (et == 0 || (et == 1 && eo == 0));
`else
            exp_warn = 1'b0;
`endif
            vectors++;
            if (tif.tick !== exp_tick || tif.tens_out !== 4'(et) || tif.ones_out !== 4'(eo) ||
                tif.time_out !== exp_to || tif.warn !== exp_warn) begin
                miscompares++;
                $display("FAIL countdown cyc=%0d got tick=%b %0d%0d to=%b warn=%b want tick=%b %0d%0d to=%b warn=%b",
                         cyc, tif.tick, tif.tens_out, tif.ones_out, tif.time_out, tif.warn,
                         exp_tick, et, eo, exp_to, exp_warn);
            end
        end
        tif.timer_enable = 1'b0;
        repeat (6) step();
        vectors++;
        if (tif.time_out !== 1'b1 || tif.tens_out !== 4'd0 || tif.ones_out !== 4'd0 || tif.tick !== 1'b0) begin
            miscompares++;
            $display("FAIL expired_sticky got %0d%0d to=%b tick=%b want 00 to=1 tick=0",
                     tif.tens_out, tif.ones_out, tif.time_out, tif.tick);
        end
    endtask

    task automatic test_reconfig_priority();
        int  guard;
        pulse_reconfig();
        vectors++;
        if (tif.time_out !== 1'b0 || tif.tens_out !== 4'd9 || tif.ones_out !== 4'd9) begin
            miscompares++;
            $display("FAIL reconfig_in_expired got %0d%0d to=%b want 99 to=0", tif.tens_out, tif.ones_out, tif.time_out);
        end
        tif.timer_enable = 1'b1;
        guard = 0;
        while (!(tif.tens_out === 4'd3 && tif.ones_out === 4'd7) && guard < 400) begin
            step();
            guard++;
        end
        vectors++;
        if (guard >= 400) begin
            miscompares++;
            $display("FAIL reach_37 got %0d%0d want 37 within 400 cycles", tif.tens_out, tif.ones_out);
        end
        repeat (3) step();
        tif.timer_reconfig = 1'b1;
        step();
        tif.timer_reconfig = 1'b0;
        vectors++;
        if (tif.tens_out !== 4'd9 || tif.ones_out !== 4'd9 || tif.tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reconfig_at_wrap got %0d%0d tick=%b want 99 tick=0", tif.tens_out, tif.ones_out, tif.tick);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            vectors++;
            if (tif.tick !== (i == 5)) begin
                miscompares++;
                $display("FAIL prescaler_cleared step=%0d got tick=%b want %b", i, tif.tick, (i == 5));
            end
        end
        tif.timer_enable = 1'b0;
    endtask

    task automatic test_pause();
        int ticks;
        pulse_reconfig();
        tif.timer_enable = 1'b1;
        ticks = 0;
        repeat (6) begin step(); if (tif.tick === 1'b1) ticks++; end
        tif.timer_enable = 1'b0;
        repeat (10) begin step(); if (tif.tick === 1'b1) ticks++; end
        vectors++;
        if (ticks != 1 || tif.tens_out !== 4'd9 || tif.ones_out !== 4'd8) begin
            miscompares++;
            $display("FAIL pause_window got ticks=%0d %0d%0d want ticks=1 98", ticks, tif.tens_out, tif.ones_out);
        end
        tif.timer_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (tif.tick !== (i == 4)) begin
                miscompares++;
                $display("FAIL resume_partial step=%0d got tick=%b want %b", i, tif.tick, (i == 4));
            end
        end
        vectors++;
        if (tif.ones_out !== 4'd7) begin
            miscompares++;
            $display("FAIL resume_digit got ones=%0d want 7", tif.ones_out);
        end
    endtask

    task automatic test_reset_midcount();
        repeat (2) step();
        rst = 1'b0;
        #1;
        vectors++;
        if ({tif.tens_out, tif.ones_out, tif.tick, tif.time_out, tif.warn} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset got t=%0d o=%0d tick=%b to=%b want 0/0/0/0",
                     tif.tens_out, tif.ones_out, tif.tick, tif.time_out);
        end
        repeat (4) step();
        vectors++;
        if (tif.tick !== 1'b0 || tif.tens_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_hold got tick=%b tens=%0d want 0/0", tif.tick, tif.tens_out);
        end
        tif.timer_enable = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_zero_preset();
        tif0.timer_reconfig = 1'b1;
        step();
        tif0.timer_reconfig = 1'b0;
        vectors++;
        if (tif0.tens_out !== 4'd0 || tif0.ones_out !== 4'd0 || tif0.time_out !== 1'b1 || tif0.tick !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_preset_load got %0d%0d to=%b tick=%b want 00 to=1 tick=0",
                     tif0.tens_out, tif0.ones_out, tif0.time_out, tif0.tick);
        end
        tif0.timer_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (tif0.time_out !== 1'b1 || tif0.tick !== 1'b0 || tif0.ones_out !== 4'd0 || tif0.warn !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_preset_enable i=%0d got to=%b tick=%b ones=%0d warn=%b want 1/0/0/0",
                         i, tif0.time_out, tif0.tick, tif0.ones_out, tif0.warn);
            end
        end
        tif0.timer_enable = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_hold_loaded();
        test_countdown();
        test_reconfig_priority();
        test_pause();
        test_reset_midcount();
        test_zero_preset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
